dark_channel_airlight: RTL

- Downstream consumer of the 3x3 line-buffer window generator in the dehazer pipeline.
- Issues window reads, computes each pixel's dark channel (min over 27 channel values of the 3x3 RGB window) in a 3-stage pipeline, and streams it to the transmission stage.
- Tracks the frame-wide maximum dark value and latches that window's centre RGB as the atmospheric light estimate.

---
 rtl/dehaze_pkg.sv | 33 +++
 rtl/pix_min3.sv | 14 +
 rtl/dark_channel_airlight.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dehaze_pkg.sv
// Shared types and helpers for the dehazer dark-channel stage.
// Provides the FSM state enum, RGB slice bounds, default frame size and min3_u8.
package dehaze_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      RUN,
      DRAIN,
      DONE
   } state_e;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   localparam int DEF_IMG_W = 100;
   localparam int DEF_IMG_H = 100;

   function automatic logic [7:0] min3_u8(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] c
   );
      logic [7:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

endpackage

// File: rtl/pix_min3.sv
// Combinational minimum of three unsigned 8-bit values.
// Ports: a, b, c in; y = min(a, b, c) out.
module pix_min3
   import dehaze_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   output logic [7:0] y
);

   assign y = min3_u8(a, b, c);

endmodule

// File: rtl/dark_channel_airlight.sv
// Dark-channel pipeline (3x3 RGB window min) with frame max / airlight tracking.
// Ports: gen_clk, rst_n, start, hold, buf_rdy, A..I in; buf_rd, dc_valid, dc_out,
// busy, frame_done, max_dark, airlight, airlight_valid out.
// DARK_COORD_EN adds al_row/al_col (raster position of the airlight pixel).
module dark_channel_airlight
   import dehaze_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PIX_W = 24
) (
   input  logic             gen_clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             hold,
   input  logic             buf_rdy,
   output logic             buf_rd,
   input  logic [PIX_W-1:0] A,
   input  logic [PIX_W-1:0] B,
   input  logic [PIX_W-1:0] C,
   input  logic [PIX_W-1:0] D,
   input  logic [PIX_W-1:0] E,
   input  logic [PIX_W-1:0] F,
   input  logic [PIX_W-1:0] G,
   input  logic [PIX_W-1:0] H,
   input  logic [PIX_W-1:0] I,
   output logic             dc_valid,
   output logic [7:0]       dc_out,
   output logic             busy,
   output logic             frame_done,
   output logic [7:0]       max_dark,
   output logic [PIX_W-1:0] airlight,
   output logic             airlight_valid
`ifdef DARK_COORD_EN
   ,
   output logic [$clog2(IMG_H)-1:0] al_row,
   output logic [$clog2(IMG_W)-1:0] al_col
`endif
);

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(NPIX + 1);
   localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(NPIX - 1);
   localparam logic [CNT_W-1:0] N_OUT   = CNT_W'(NPIX);

   state_e state_q, state_d;
   logic   buf_rd_c, frame_done_c, start_go;

   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

   logic [8:0][PIX_W-1:0] win;
   logic [8:0][7:0]       pm, s1_q, s1_d;
   logic [2:0][7:0]       gm, s2_q, s2_d;
   logic [7:0]            fm;

   logic v0_q, s1_v_q, s2_v_q, dc_valid_q;
   logic v0_d, s1_v_d, s2_v_d, dc_valid_d;
   logic [PIX_W-1:0] e1_q, e2_q, e3_q;
   logic [PIX_W-1:0] e1_d, e2_d, e3_d;
   logic [7:0]       dc_out_q, dc_out_d;

   logic [7:0]       max_dark_q, max_dark_d;
   logic [PIX_W-1:0] airlight_q, airlight_d;
   logic             al_valid_q, al_valid_d;
   logic             new_max;

   assign win = {I, H, G, F, E, D, C, B, A};

   // Stage 1 reduction: per-pixel min over R, G, B.
   for (genvar p = 0; p < 9; p++) begin : g_pix
      pix_min3 u_pix (
         .a (win[p][R_HI:R_LO]),
         .b (win[p][G_HI:G_LO]),
         .c (win[p][B_HI:B_LO]),
         .y (pm[p])
      );
   end

   // Stage 2 reduction: min per window row.
   for (genvar r = 0; r < 3; r++) begin : g_row
      pix_min3 u_row (
         .a (s1_q[3*r]),
         .b (s1_q[3*r+1]),
         .c (s1_q[3*r+2]),
         .y (gm[r])
      );
   end

   pix_min3 u_fin (
      .a (s2_q[0]),
      .b (s2_q[1]),
      .c (s2_q[2]),
      .y (fm)
   );

   always_comb begin
      state_d      = state_q;
      buf_rd_c     = 1'b0;
      frame_done_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (buf_rdy) state_d = RUN;
         end
         RUN: begin
            buf_rd_c = !hold;
            if (buf_rd_c && rd_cnt_q == LAST_RD) state_d = DRAIN;
         end
         DRAIN: begin
            if (out_cnt_q == N_OUT) state_d = DONE;
         end
         DONE: begin
            frame_done_c = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      v0_d       = buf_rd_c;
      s1_v_d     = v0_q;
      s2_v_d     = s1_v_q;
      dc_valid_d = s2_v_q;
      s1_d       = pm;
      s2_d       = gm;
      e1_d       = E;
      e2_d       = e1_q;
      e3_d       = e2_q;
      dc_out_d   = s2_v_q ? fm : dc_out_q;
   end

   assign start_go = (state_q == IDLE) && start;
   assign new_max  = dc_valid_q && (dc_out_q > max_dark_q);

   always_comb begin
      rd_cnt_d   = rd_cnt_q;
      out_cnt_d  = out_cnt_q;
      max_dark_d = max_dark_q;
      airlight_d = airlight_q;
      al_valid_d = al_valid_q;
      if (start_go) begin
         rd_cnt_d   = '0;
         out_cnt_d  = '0;
         max_dark_d = '0;
         airlight_d = '0;
         al_valid_d = 1'b0;
      end else begin
         if (buf_rd_c) rd_cnt_d = rd_cnt_q + CNT_W'(1);
         if (dc_valid_q) out_cnt_d = out_cnt_q + CNT_W'(1);
         // Strict compare keeps the earliest pixel on ties.
         if (new_max) begin
            max_dark_d = dc_out_q;
            airlight_d = e3_q;
         end
         if (state_q == DONE) al_valid_d = 1'b1;
      end
   end

   always_ff @(posedge gen_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_cnt_q   <= '0;
         out_cnt_q  <= '0;
         v0_q       <= 1'b0;
         s1_v_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         dc_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
         e1_q       <= '0;
         e2_q       <= '0;
         e3_q       <= '0;
         dc_out_q   <= '0;
         max_dark_q <= '0;
         airlight_q <= '0;
         al_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         out_cnt_q  <= out_cnt_d;
         v0_q       <= v0_d;
         s1_v_q     <= s1_v_d;
         s2_v_q     <= s2_v_d;
         dc_valid_q <= dc_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         e1_q       <= e1_d;
         e2_q       <= e2_d;
         e3_q       <= e3_d;
         dc_out_q   <= dc_out_d;
         max_dark_q <= max_dark_d;
         airlight_q <= airlight_d;
         al_valid_q <= al_valid_d;
      end
   end

`ifdef DARK_COORD_EN
   localparam int ROW_W = $clog2(IMG_H);
   localparam int COL_W = $clog2(IMG_W);

   // Raster position of the sample currently on dc_out (no divider needed).
   logic [ROW_W-1:0] row_q, row_d, al_row_q, al_row_d;
   logic [COL_W-1:0] col_q, col_d, al_col_q, al_col_d;

   always_comb begin
      row_d    = row_q;
      col_d    = col_q;
      al_row_d = al_row_q;
      al_col_d = al_col_q;
      if (start_go) begin
         row_d    = '0;
         col_d    = '0;
         al_row_d = '0;
         al_col_d = '0;
      end else begin
         if (new_max) begin
            al_row_d = row_q;
            al_col_d = col_q;
         end
         if (dc_valid_q) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
               col_d = '0;
               row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge gen_clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q    <= '0;
         col_q    <= '0;
         al_row_q <= '0;
         al_col_q <= '0;
      end else begin
         row_q    <= row_d;
         col_q    <= col_d;
         al_row_q <= al_row_d;
         al_col_q <= al_col_d;
      end
   end

   assign al_row = al_row_q;
   assign al_col = al_col_q;
`endif

   assign buf_rd         = buf_rd_c;
   assign dc_valid       = dc_valid_q;
   assign dc_out         = dc_out_q;
   assign busy           = (state_q != IDLE);
   assign frame_done     = frame_done_c;
   assign max_dark       = max_dark_q;
   assign airlight       = airlight_q;
   assign airlight_valid = al_valid_q;

endmodule
